// File: rtl/nibbler_ram_arbiter.sv
// nibbler_ram_arbiter: shares the 4K x 4 data RAM between the CPU (zero-latency pass-through) and a debug port.
// Define NIB_ARB_WRPROT_EN to reject debug writes below PROT_LIMIT (flagged on dbgErr).
module nibbler_ram_arbiter #(
    parameter int          STARVE_W     = 3,
    parameter int          STARVE_LIMIT = 4,
    parameter logic [11:0] PROT_LIMIT   = 12'h100
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpuReq,
    input  logic        cpuWe,
    input  logic [11:0] cpuAddr,
    input  logic [3:0]  cpuWdata,
    output logic [3:0]  cpuRdata,
    output logic        cpuStall,
    input  logic        dbgReq,
    input  logic        dbgWe,
    input  logic [11:0] dbgAddr,
    input  logic [3:0]  dbgWdata,
    output logic        dbgAck,
    output logic [3:0]  dbgRdata,
    output logic        dbgErr,
    output logic        ramCs,
    output logic        ramWe,
    output logic [11:0] ramAddr,
    output logic [3:0]  ramWdata,
    input  logic [3:0]  ramRdata
);
    typedef enum logic [2:0] {IDLE, D_SETUP, D_STROBE, D_ACK, D_WAIT} state_t;
`ifdef NIB_ARB_WRPROT_EN
    localparam bit WRPROT = 1'b1;
`else
    localparam bit WRPROT = 1'b0;
`endif
    localparam logic [STARVE_W-1:0] LIMIT = STARVE_W'(STARVE_LIMIT);
    state_t state, state_nx;
    logic [STARVE_W-1:0] starve, starve_nx;
    logic [11:0] addr_q;
    logic [3:0] wdata_q;
    logic we_q, prot_q, prot, forced, grant;
    assign prot = WRPROT && dbgWe && (dbgAddr < PROT_LIMIT);
    assign forced = (state == IDLE) && dbgReq && cpuReq && (starve >= LIMIT);
    assign grant = (state == IDLE) && dbgReq && (!cpuReq || forced);
    assign dbgAck = (state == D_ACK);
    assign dbgErr = dbgAck && prot_q;
    assign cpuRdata = ramRdata;
    always_comb begin
        state_nx = state;
        starve_nx = starve;
        ramCs = cpuReq;
        ramWe = cpuWe;
        ramAddr = cpuAddr;
        ramWdata = cpuWdata;
        cpuStall = 1'b0;
        case (state)
            IDLE: begin
                if (grant) begin
                    state_nx = D_SETUP;
                    starve_nx = '0;
                end else if (dbgReq && cpuReq) begin
                    starve_nx = (starve == '1) ? starve : starve + 1'b1;
                end
                if (forced) begin
                    ramCs = 1'b0;
                    ramWe = 1'b0;
                    ramAddr = '0;
                    ramWdata = '0;
                    cpuStall = 1'b1;
                end
            end
            D_SETUP: begin
                ramCs = 1'b1;
                ramWe = 1'b0;
                ramAddr = addr_q;
                ramWdata = wdata_q;
                cpuStall = cpuReq;
                state_nx = D_STROBE;
            end
            D_STROBE: begin
                ramCs = !prot_q;
                ramWe = we_q && !prot_q;
                ramAddr = addr_q;
                ramWdata = wdata_q;
                cpuStall = cpuReq;
                state_nx = D_ACK;
            end
            D_ACK: state_nx = D_WAIT;
            D_WAIT: state_nx = dbgReq ? D_WAIT : IDLE;
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            starve <= '0;
            dbgRdata <= '0;
            addr_q <= '0;
            wdata_q <= '0;
            we_q <= 1'b0;
            prot_q <= 1'b0;
        end else begin
            state <= state_nx;
            starve <= starve_nx;
            if (grant) begin
                addr_q <= dbgAddr;
                wdata_q <= dbgWdata;
                we_q <= dbgWe;
                prot_q <= prot;
            end
            // a rejected write leaves the last captured read data visible
            if (state == D_STROBE && !prot_q)
                dbgRdata <= ramRdata;
        end
    end
endmodule

// File: tb/tb_nibbler_ram_arbiter.sv
// tb_nibbler_ram_arbiter: directed bench with a cycle-level model of the arbitration rules and a RAM behind the DUT.
module tb_nibbler_ram_arbiter;
    localparam int SW = 3;
    localparam int LIM = 4;
    localparam logic [11:0] PL = 12'h100;
`ifdef NIB_ARB_WRPROT_EN
    localparam bit WRPROT = 1'b1;
`else
    localparam bit WRPROT = 1'b0;
`endif
    logic clk = 0, reset = 1;
    logic cpuReq = 0, cpuWe = 0, dbgReq = 0, dbgWe = 0;
    logic [11:0] cpuAddr = 0, dbgAddr = 0;
    logic [3:0] cpuWdata = 0, dbgWdata = 0;
    logic [3:0] cpuRdata, dbgRdata, ramWdata, ramRdata;
    logic cpuStall, dbgAck, dbgErr, ramCs, ramWe;
    logic [11:0] ramAddr;
    logic [3:0] mem [0:4095];
    int checks = 0, errors = 0;

    nibbler_ram_arbiter #(.STARVE_W(SW), .STARVE_LIMIT(LIM), .PROT_LIMIT(PL)) dut (
        .clk(clk), .reset(reset), .cpuReq(cpuReq), .cpuWe(cpuWe), .cpuAddr(cpuAddr),
        .cpuWdata(cpuWdata), .cpuRdata(cpuRdata), .cpuStall(cpuStall), .dbgReq(dbgReq),
        .dbgWe(dbgWe), .dbgAddr(dbgAddr), .dbgWdata(dbgWdata), .dbgAck(dbgAck),
        .dbgRdata(dbgRdata), .dbgErr(dbgErr), .ramCs(ramCs), .ramWe(ramWe),
        .ramAddr(ramAddr), .ramWdata(ramWdata), .ramRdata(ramRdata)
    );

    always #5 clk = ~clk;
    assign ramRdata = mem[ramAddr];
    always @(posedge clk) if (ramCs && ramWe) mem[ramAddr] <= ramWdata;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // model: m_ph counts cycles since a debug grant (1 setup, 2 strobe, 3 ack, 4 waiting for release)
    int m_ph = 0, m_starve = 0;
    logic [11:0] m_a = 0;
    logic [3:0] m_wd = 0, m_rd = 0;
    logic m_we = 0, m_err = 0;
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_ph <= 0;
            m_starve <= 0;
            m_rd <= 0;
        end else if (m_ph == 0) begin
            if (dbgReq && (!cpuReq || m_starve >= LIM)) begin
                m_ph <= 1;
                m_starve <= 0;
                m_a <= dbgAddr;
                m_we <= dbgWe;
                m_wd <= dbgWdata;
                m_err <= WRPROT && dbgWe && (dbgAddr < PL);
            end else if (dbgReq && cpuReq) m_starve <= m_starve + 1;
        end else if (m_ph == 2) begin
            m_ph <= 3;
            if (!m_err) m_rd <= mem[m_a];
        end else if (m_ph == 4) begin
            if (!dbgReq) m_ph <= 0;
        end else m_ph <= m_ph + 1;
    end

    always @(negedge clk) begin : cmp
        logic fx;
        fx = (m_ph == 0) && dbgReq && cpuReq && (m_starve >= LIM);
        if (fx) begin
            chk("forced_cs", ramCs, 0);
            chk("forced_we", ramWe, 0);
            chk("forced_addr", ramAddr, 0);
            chk("forced_wdata", ramWdata, 0);
        end else if (m_ph == 1 || m_ph == 2) begin
            chk("dbg_cs", ramCs, (m_ph == 1) ? 1 : !m_err);
            chk("dbg_we", ramWe, (m_ph == 2) && m_we && !m_err);
            chk("dbg_addr", ramAddr, m_a);
            if (m_ph == 2 && m_we && !m_err) chk("dbg_wdata", ramWdata, m_wd);
        end else begin
            chk("pass_cs", ramCs, cpuReq);
            chk("pass_we", ramWe, cpuWe);
            chk("pass_addr", ramAddr, cpuAddr);
            chk("pass_wdata", ramWdata, cpuWdata);
            chk("pass_rdata", cpuRdata, ramRdata);
        end
        chk("stall", cpuStall, fx || ((m_ph == 1 || m_ph == 2) && cpuReq));
        chk("ack", dbgAck, m_ph == 3);
        chk("err", dbgErr, (m_ph == 3) && m_err);
        chk("dbg_rdata", dbgRdata, m_rd);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ack(input bit drop, output int cyc, output int stalls);
        bit ok = 0;
        cyc = 0;
        stalls = 0;
        repeat (20) begin
            #2;
            cyc++;
            stalls += int'(cpuStall);
            if (dbgAck) begin
                ok = 1;
                break;
            end
            step();
            if (drop && cyc == 1) begin
                dbgReq = 0;
                dbgAddr = ~dbgAddr;
            end
        end
        if (!ok) chk("ack_timeout", 0, 1);
    endtask

    initial begin
        int cyc, stalls, n;
        for (int i = 0; i < 4096; i++) mem[i] = 4'h0;
        mem[12'h3F0] = 4'hC;
        mem[12'h300] = 4'h2;
        mem[12'h050] = 4'h3;
        repeat (2) @(posedge clk);
        #1 reset = 0;
        step();
        // CPU write passes straight through
        cpuReq = 1; cpuWe = 1; cpuAddr = 12'h0A5; cpuWdata = 4'h7;
        #1;
        chk("t1_cs", ramCs, 1);
        chk("t1_we", ramWe, 1);
        chk("t1_addr", ramAddr, 12'h0A5);
        chk("t1_stall", cpuStall, 0);
        step();
        cpuReq = 0; cpuWe = 0;
        chk("t1_mem", mem[12'h0A5], 4'h7);
        // idle CPU, debug read; request dropped and address changed after grant
        dbgReq = 1; dbgWe = 0; dbgAddr = 12'h3F0;
        wait_ack(1, cyc, stalls);
        chk("t2_latency", cyc, 4);
        chk("t2_stalls", stalls, 0);
        chk("t2_rdata", dbgRdata, 4'hC);
        step();
        step();
        // CPU keeps the RAM busy: four served cycles, three stalled, then ack
        cpuReq = 1; cpuAddr = 12'h123;
        dbgReq = 1; dbgWe = 1; dbgAddr = 12'h200; dbgWdata = 4'h9;
        wait_ack(0, cyc, stalls);
        chk("t3_total", cyc, 8);
        chk("t3_stalls", stalls, 3);
        step();
        dbgReq = 0; cpuReq = 0;
        step();
        dbgReq = 1; dbgWe = 0; dbgAddr = 12'h200;
        wait_ack(0, cyc, stalls);
        chk("t3_readback", dbgRdata, 4'h9);
        // held request does not retrigger; release and re-raise does
        dbgAddr = 12'h3F0;
        n = 0;
        repeat (5) begin
            step();
            #1;
            n += int'(dbgAck);
        end
        chk("t4_no_second", n, 0);
        dbgReq = 0;
        step();
        step();
        dbgReq = 1;
        wait_ack(0, cyc, stalls);
        chk("t4_second_lat", cyc, 4);
        chk("t4_rdata", dbgRdata, 4'hC);
        step();
        dbgReq = 0;
        step();
        // debug write into the low region
        dbgReq = 1; dbgWe = 1; dbgAddr = 12'h050; dbgWdata = 4'hF;
        wait_ack(0, cyc, stalls);
        chk("t6_err", dbgErr, WRPROT);
        step();
        dbgReq = 0;
        chk("t6_mem", mem[12'h050], WRPROT ? 4'h3 : 4'hF);
        step();
        // reset during the strobe cycle aborts the write
        dbgReq = 1; dbgWe = 1; dbgAddr = 12'h300; dbgWdata = 4'h5;
        step();
        step();
        reset = 1;
        #1;
        chk("t5_ack", dbgAck, 0);
        chk("t5_rdata", dbgRdata, 0);
        chk("t5_stall", cpuStall, 0);
        chk("t5_cs", ramCs, 0);
        dbgReq = 0;
        step();
        reset = 0;
        n = 0;
        repeat (4) begin
            step();
            #1;
            n += int'(dbgAck);
        end
        chk("t5_no_ack", n, 0);
        chk("t5_mem", mem[12'h300], 4'h2);
        cpuReq = 1; cpuWe = 0; cpuAddr = 12'h0A5;
        #1;
        chk("t5_pass_cs", ramCs, 1);
        chk("t5_pass_addr", ramAddr, 12'h0A5);
        chk("t5_pass_rdata", cpuRdata, 4'h7);
        step();
        cpuReq = 0;
        step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
